// File: rtl/register_status_table_if.sv
// Issue, lookup, CDB and flush signals between the issue stage and the register status table.
// The table sits on the slave modport.
interface register_status_table_if #(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3
);
  logic                Issue_valid;
  logic [REG_AW-1:0]   Issue_rd;
  logic [TAG_W-1:0]    Issue_tag;
  logic [REG_AW-1:0]   Issue_rs;
  logic [REG_AW-1:0]   Issue_rt;
  logic [TAG_W-1:0]    Rs_Qj;
  logic [TAG_W-1:0]    Rs_Qk;
  logic [DATA_W-1:0]   Rs_Vj;
  logic [DATA_W-1:0]   Rs_Vk;
  logic                CDB_valid;
  logic [TAG_W-1:0]    CDB_tag;
  logic [DATA_W-1:0]   CDB_data;
  logic                Flush;
  logic [NUM_REGS-1:0] Busy_mask;

  modport master (
    output Issue_valid, Issue_rd, Issue_tag, Issue_rs, Issue_rt,
    output CDB_valid, CDB_tag, CDB_data, Flush,
    input  Rs_Qj, Rs_Qk, Rs_Vj, Rs_Vk, Busy_mask
  );

  modport slave (
    input  Issue_valid, Issue_rd, Issue_tag, Issue_rs, Issue_rt,
    input  CDB_valid, CDB_tag, CDB_data, Flush,
    output Rs_Qj, Rs_Qk, Rs_Vj, Rs_Vk, Busy_mask
  );
endinterface

// File: rtl/register_status_table.sv
// Tomasulo register status table: per-register producer tag (Qi) and committed data,
// with tag renaming at issue, tag-matched CDB write-back, flush and two bypassed lookup ports.
module register_status_table #(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(1)
) (
  input logic                    Clock,
  input logic                    Reset,
  register_status_table_if.slave bus
);
  logic [TAG_W-1:0]    qi     [NUM_REGS];
  logic [DATA_W-1:0]   data_q [NUM_REGS];
  logic                cdb_ok;
  logic                issue_ok;
  logic [NUM_REGS-1:0] cdb_hit;
  logic [NUM_REGS-1:0] issue_hit;
  logic [NUM_REGS-1:0] busy;
  logic [TAG_W-1:0]    qj, qk;
  logic [DATA_W-1:0]   vj, vk;

  function automatic logic in_range(input logic [REG_AW-1:0] idx);
    return {1'b0, idx} < (REG_AW+1)'(NUM_REGS);
  endfunction

  assign cdb_ok   = bus.CDB_valid && (bus.CDB_tag != '0);
  assign issue_ok = bus.Issue_valid && (bus.Issue_tag != '0) && !bus.Flush &&
                    in_range(bus.Issue_rd);

  always_comb begin
    cdb_hit   = '0;
    issue_hit = '0;
    busy      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cdb_hit[i]   = cdb_ok && (qi[i] == bus.CDB_tag);
      issue_hit[i] = issue_ok && (bus.Issue_rd == REG_AW'(i));
      busy[i]      = (qi[i] != '0);
    end
  end

  // A same-cycle rename beats the CDB clear: the newer producer owns the tag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        qi[i]     <= '0;
        data_q[i] <= RESET_DATA;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cdb_hit[i])
          data_q[i] <= bus.CDB_data;
        if (issue_hit[i])
          qi[i] <= bus.Issue_tag;
        else if (bus.Flush || cdb_hit[i])
          qi[i] <= '0;
      end
    end
  end

  // Lookups read pre-edge state; a matching CDB broadcast is forwarded directly.
  always_comb begin
    qj = '0;
    vj = '0;
    qk = '0;
    vk = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.Issue_rs == REG_AW'(i)) begin
        qj = qi[i];
        vj = data_q[i];
      end
      if (bus.Issue_rt == REG_AW'(i)) begin
        qk = qi[i];
        vk = data_q[i];
      end
    end
    if (cdb_ok && (qj == bus.CDB_tag)) begin
      qj = '0;
      vj = bus.CDB_data;
    end
    if (cdb_ok && (qk == bus.CDB_tag)) begin
      qk = '0;
      vk = bus.CDB_data;
    end
  end

  assign bus.Rs_Qj     = qj;
  assign bus.Rs_Vj     = vj;
  assign bus.Rs_Qk     = qk;
  assign bus.Rs_Vk     = vk;
  assign bus.Busy_mask = busy;
endmodule

// File: doc/register_status_table.md
# register_status_table

Parametrised register status table for the Tomasulo issue/write-back path. It holds, for each architectural register, the reservation-station tag (Qi) that will produce its next value, together with the committed data value. It provides two source-operand lookup ports with same-cycle CDB bypass for the issue stage. It adds tag renaming at issue, tag-matched CDB write-back, a pipeline flush, and a busy mask to the previous fixed three-register, single-station table.

## Interface
- NUM_REGS, 8, number of architectural registers
- REG_AW, 3, register index width; must satisfy 2^REG_AW >= NUM_REGS
- DATA_W, 16, register data width
- TAG_W, 3, station tag width; tag 0 means FREE (no pending producer)
- RESET_DATA, 1, value loaded into every register on reset

- Clock  in  1  single clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset (asserted at 0)
- Issue_valid  in  1  rename request this cycle
- Issue_rd  in  REG_AW  destination register of the issuing instruction
- Issue_tag  in  TAG_W  station tag that will produce Issue_rd
- Issue_rs, Issue_rt  in  REG_AW  source register indices to look up
- Rs_Qj, Rs_Qk  out  TAG_W  pending tag for rs/rt (0 = value ready)
- Rs_Vj, Rs_Vk  out  DATA_W  value for rs/rt, valid when the matching Q is 0
- CDB_valid  in  1  common data bus broadcast this cycle
- CDB_tag  in  TAG_W  tag of the broadcasting station
- CDB_data  in  DATA_W  broadcast result
- Flush  in  1  discard all pending renames
- Busy_mask  out  NUM_REGS  bit i = 1 while register i has a nonzero Qi

## Operation
- State: Qi[NUM_REGS] (TAG_W each) and Data[NUM_REGS] (DATA_W each).
- Reset (Reset=0): all Qi=0, all Data=RESET_DATA, Busy_mask=0. Takes effect immediately and asynchronously, including mid-operation.
- CDB write-back applies when CDB_valid=1 and CDB_tag!=0. For every i with Qi[i]==CDB_tag: Data[i]<=CDB_data and Qi[i]<=0. Multiple matches are all updated.
- CDB_valid=1 with CDB_tag=0 is ignored.
- Issue applies when Issue_valid=1, Issue_tag!=0 and Issue_rd<NUM_REGS. Then Qi[Issue_rd]<=Issue_tag and Data is unchanged.
- Issue with Issue_tag=0 or an out-of-range Issue_rd is ignored.
- Issue and CDB hit the same register in the same cycle: Data takes CDB_data and Qi takes Issue_tag. The newer rename wins the tag.
- Flush=1: all Qi<=0 and any issue that cycle is ignored. CDB data writes for matching registers still occur.
- Lookup ports are combinational and read pre-edge state:
  - Rs_Qj=Qi[rs] and Rs_Vj=Data[rs].
  - If CDB_valid, CDB_tag!=0 and Qi[rs]==CDB_tag, then Rs_Qj=0 and Rs_Vj=CDB_data (bypass).
  - The rt port behaves identically.
- Lookups do not see this cycle's issue. An instruction with rs==rd therefore gets the older producer, which is correct rename semantics.
- An out-of-range rs/rt returns Q=0 and V=0.
- Busy_mask[i] = (Qi[i]!=0), driven from registered state.

## Timing
- Lookup: zero-cycle latency, purely combinational from state plus CDB inputs.
- Issue: the new Qi is visible on the lookup ports and Busy_mask in the cycle after the edge.
- CDB write-back: Data/Qi update at the edge. The same-cycle value is available through the bypass.
- Flush: Busy_mask=0 in the cycle after the edge.
- No handshake: every input is sampled once per edge, and the block never stalls.
- Deasserting reset takes effect on the first rising edge with Reset=1.

## Test plan
- Reset release: Data all 1 and Qi all 0. Lookup rs=5 -> Rs_Qj=0, Rs_Vj=1. Busy_mask=0x00.
- Issue rd=2, tag=3. Next cycle lookup rs=2 -> Rs_Qj=3 and Busy_mask=0x04. Then CDB tag=3, data=0x00AB in the same cycle as lookup rs=2 -> Rs_Qj=0, Rs_Vj=0x00AB (bypass). Next cycle Data[2]=0x00AB and Busy_mask=0x00.
- Rename over pending:
  - Issue rd=1, tag=2, then issue rd=1, tag=4.
  - CDB tag=2, data=0x1111 -> Qi[1] stays 4 and Busy_mask bit1 stays 1.
  - CDB tag=4, data=0x2222 -> Qi[1]=0 and Data[1]=0x2222.
- Simultaneous issue and CDB: Qi[6]=5. In one cycle, issue rd=6, tag=1 and CDB tag=5, data=0x0F0F -> Qi[6]=1 and Data[6]=0x0F0F.
- Multi-match and flush:
  - Issue rd=0 and rd=7, both tag=2. CDB tag=2, data=0x0033 -> both registers free with data 0x0033.
  - Pend rd=3 with tag=6. Flush with concurrent issue rd=4, tag=1 -> Busy_mask=0x00 next cycle.
- Async reset mid-operation: with Busy_mask=0x0F, drive Reset low between edges -> Busy_mask=0x00 and lookups return Q=0, V=1 immediately, before the next clock edge.
